// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a one-entry holding register; 8N1 frames at CLK_DIV clocks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic [7:0]      hold_data, hold_data_next;
  logic            hold_valid, hold_valid_next;
  logic            bit_end;
  logic            load;
  logic            accept;
`ifdef UART_TX_PARITY_EN
  logic            par, par_next;
`endif

  assign bit_end = (cnt == LAST);
  assign accept  = tx_valid && !hold_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      hold_data  <= '0;
      hold_valid <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      hold_data  <= hold_data_next;
      hold_valid <= hold_valid_next;
`ifdef UART_TX_PARITY_EN
      par        <= par_next;
`endif
    end
  end

  // The shifter is loaded from the holding register either from IDLE or straight out of
  // the last STOP cycle, which is what gives zero-gap back-to-back frames.
  always_comb begin
    state_next      = state;
    load            = 1'b0;
    cnt_next        = cnt;
    bit_idx_next    = bit_idx;
    shift_next      = shift;
    hold_data_next  = hold_data;
    hold_valid_next = hold_valid;
`ifdef UART_TX_PARITY_EN
    par_next        = par;
`endif
    unique case (state)
      IDLE:  if (hold_valid) begin
               state_next = START;
               load       = 1'b1;
             end
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
               state_next = PARITY;
`else
               state_next = STOP;
`endif
             end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) state_next = STOP;
`endif
      STOP:  if (bit_end) begin
               if (hold_valid) begin
                 state_next = START;
                 load       = 1'b1;
               end else begin
                 state_next = IDLE;
               end
             end
      default: state_next = IDLE;
    endcase

    if (state == IDLE || bit_end) cnt_next = '0;
    else                          cnt_next = cnt + 1'b1;

    if (load) begin
      shift_next   = hold_data;
      bit_idx_next = 3'd0;
`ifdef UART_TX_PARITY_EN
      par_next     = ^hold_data;
`endif
    end else if (state == DATA && bit_end) begin
      shift_next = {1'b0, shift[7:1]};
      if (bit_idx != 3'd7) bit_idx_next = bit_idx + 3'd1;
    end

    if (load) begin
      hold_valid_next = 1'b0;
    end else if (accept) begin
      hold_valid_next = 1'b1;
      hold_data_next  = tx_data;
    end
  end

  always_comb begin
    tx      = 1'b1;
    tx_done = 1'b0;
    unique case (state)
      IDLE:   tx = 1'b1;
      START:  tx = 1'b0;
      DATA:   tx = shift[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = par;
`endif
      STOP:   begin
                tx      = 1'b1;
                tx_done = bit_end;
              end
      default: tx = 1'b1;
    endcase
    busy     = (state != IDLE) || hold_valid;
    tx_ready = !hold_valid;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scenario tasks for uart_tx at CLK_DIV=4, checked against a frame-level timing model.
// Follows UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * D;
  localparam int W  = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, tx_done;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  uart_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit j of a frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic frame_bit(input logic [7:0] b, input int off);
    int idx;
    idx = off / D;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Cycle 0 is the cycle after the first handshake. Byte i is offered from cycle p[i],
  // accepted once the holding slot is free, and starts no earlier than two cycles after
  // acceptance and no earlier than the end of the previous frame.
  task automatic model_frames(input logic [7:0] b [4], input int p [4], input int nb,
                              output int n, output logic [W-1:0] le, output logic [W-1:0] de,
                              output logic [W-1:0] be, output logic [W-1:0] re);
    int h [4];
    int s [4];
    logic occ, inf, ln, dn;
    h[0] = -1;
    s[0] = 1;
    for (int i = 1; i < nb; i++) begin
      h[i] = (p[i] > s[i-1]) ? p[i] : s[i-1];
      s[i] = (h[i] + 2 > s[i-1] + FL) ? h[i] + 2 : s[i-1] + FL;
    end
    n  = s[nb-1] + FL + 3;
    le = '0; de = '0; be = '0; re = '0;
    for (int c = 0; c < n; c++) begin
      occ = 1'b0; inf = 1'b0; ln = 1'b1; dn = 1'b0;
      for (int i = 0; i < nb; i++) begin
        if (c >= s[i] && c < s[i] + FL) begin
          inf = 1'b1;
          ln  = frame_bit(b[i], c - s[i]);
          dn  = (c == s[i] + FL - 1);
        end
        if (c >= h[i] + 1 && c <= s[i] - 1) occ = 1'b1;
      end
      le[c] = ln; de[c] = dn; be[c] = occ | inf; re[c] = ~occ;
    end
  endtask

  // Offers the bytes at the given cycles and records tx/tx_done/busy/tx_ready for n cycles.
  task automatic run_seq(input logic [7:0] b [4], input int p [4], input int nb, input int n,
                         output logic [W-1:0] lo, output logic [W-1:0] dout,
                         output logic [W-1:0] bo, output logic [W-1:0] ro, output bit timeout);
    int k0;
    logic [W-1:0] lv, dv, bv, rv;
    bit to;
    lv = '0; dv = '0; bv = '0; rv = '0; to = 1'b0;
    @(negedge clk);
    tx_data  = b[0];
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    k0 = cyc;
    fork
      begin
        for (int c = 0; c < n; c++) begin
          @(negedge clk);
          lv[c] = tx; dv[c] = tx_done; bv[c] = busy; rv[c] = tx_ready;
        end
      end
      begin
        for (int i = 1; i < nb; i++) begin
          int waited;
          logic rdy;
          while (cyc - k0 < p[i]) begin
            @(posedge clk);
            #1;
          end
          tx_data  = b[i];
          tx_valid = 1'b1;
          waited   = 0;
          rdy      = 1'b0;
          while (!rdy && waited < 4 * FL) begin
            @(negedge clk);
            rdy = tx_ready;
            @(posedge clk);
            #1;
            waited++;
          end
          tx_valid = 1'b0;
          if (!rdy) to = 1'b1;
        end
      end
    join
    lo = lv; dout = dv; bo = bv; ro = rv; timeout = to;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #10;
    n_cmp += 4;
    if (tx !== 1'b1)       begin n_err++; $display("[TB] FAIL reset tx: got %b want 1", tx); end
    if (tx_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset tx_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0)     begin n_err++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    if (tx_done !== 1'b0)  begin n_err++; $display("[TB] FAIL reset tx_done: got %b want 0", tx_done); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (tx !== 1'b1)   begin n_err++; $display("[TB] FAIL idle tx: got %b want 1", tx); end
    if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL idle busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [7:0] b [4];
    int p [4];
    int n;
    bit to;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    b = '{8'h55, 8'h00, 8'h00, 8'h00};
    p = '{0, 0, 0, 0};
    model_frames(b, p, 1, n, le, de, be, re);
    run_seq(b, p, 1, n, lg, dg, bg, rg, to);
    n_cmp += 7;
    if (to !== 1'b0) begin n_err++; $display("[TB] FAIL single timeout: got %b want 0", to); end
    if (lg !== le) begin n_err++; $display("[TB] FAIL single tx: got %h want %h", lg, le); end
    if (dg !== de) begin n_err++; $display("[TB] FAIL single tx_done: got %h want %h", dg, de); end
    if (bg !== be) begin n_err++; $display("[TB] FAIL single busy: got %h want %h", bg, be); end
    if (rg !== re) begin n_err++; $display("[TB] FAIL single tx_ready: got %h want %h", rg, re); end
    if (dg[FL] !== 1'b1)   begin n_err++; $display("[TB] FAIL single done_at_end: got %b want 1", dg[FL]); end
    if (bg[FL+1] !== 1'b0) begin n_err++; $display("[TB] FAIL single busy_after: got %b want 0", bg[FL+1]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [4];
    int p [4];
    int n;
    bit to;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    b = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    p = '{0, 11, 20, 0};
    model_frames(b, p, 3, n, le, de, be, re);
    run_seq(b, p, 3, n, lg, dg, bg, rg, to);
    n_cmp += 7;
    if (to !== 1'b0) begin n_err++; $display("[TB] FAIL b2b timeout: got %b want 0", to); end
    if (lg !== le) begin n_err++; $display("[TB] FAIL b2b tx: got %h want %h", lg, le); end
    if (dg !== de) begin n_err++; $display("[TB] FAIL b2b tx_done: got %h want %h", dg, de); end
    if (bg !== be) begin n_err++; $display("[TB] FAIL b2b busy: got %h want %h", bg, be); end
    if (rg !== re) begin n_err++; $display("[TB] FAIL b2b tx_ready: got %h want %h", rg, re); end
    if (dg[2*FL] !== 1'b1)   begin n_err++; $display("[TB] FAIL b2b second_done: got %b want 1", dg[2*FL]); end
    if (lg[FL+1] !== 1'b0)   begin n_err++; $display("[TB] FAIL b2b no_gap_start: got %b want 0", lg[FL+1]); end
  endtask

  task automatic test_stop_handshake();
    logic [7:0] b [4];
    int p [4];
    int n;
    bit to;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    b = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    p = '{0, FL, 0, 0};
    model_frames(b, p, 2, n, le, de, be, re);
    run_seq(b, p, 2, n, lg, dg, bg, rg, to);
    n_cmp += 7;
    if (to !== 1'b0) begin n_err++; $display("[TB] FAIL stophs timeout: got %b want 0", to); end
    if (lg !== le) begin n_err++; $display("[TB] FAIL stophs tx: got %h want %h", lg, le); end
    if (dg !== de) begin n_err++; $display("[TB] FAIL stophs tx_done: got %h want %h", dg, de); end
    if (bg !== be) begin n_err++; $display("[TB] FAIL stophs busy: got %h want %h", bg, be); end
    if (rg !== re) begin n_err++; $display("[TB] FAIL stophs tx_ready: got %h want %h", rg, re); end
    if (lg[FL+1] !== 1'b1) begin n_err++; $display("[TB] FAIL stophs idle_cycle: got %b want 1", lg[FL+1]); end
    if (lg[FL+2] !== 1'b0) begin n_err++; $display("[TB] FAIL stophs start_after_idle: got %b want 0", lg[FL+2]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b [4];
    int p [4];
    int n, k0;
    bit to, quiet;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    @(negedge clk);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    k0 = cyc;
    tx_data = 8'h5A;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    while (cyc - k0 < 4 * D + 2) begin
      @(posedge clk);
      #1;
    end
    n_cmp += 1;
    if (tx !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid bit3: got %b want 0", tx); end
    rst = 1'b0;
    #1;
    n_cmp += 4;
    if (tx !== 1'b1)       begin n_err++; $display("[TB] FAIL rstmid tx: got %b want 1", tx); end
    if (tx_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid tx_ready: got %b want 1", tx_ready); end
    if (busy !== 1'b0)     begin n_err++; $display("[TB] FAIL rstmid busy: got %b want 0", busy); end
    if (tx_done !== 1'b0)  begin n_err++; $display("[TB] FAIL rstmid tx_done: got %b want 0", tx_done); end
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    quiet = 1'b1;
    for (int c = 0; c < FL + 4; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) quiet = 1'b0;
    end
    n_cmp += 1;
    if (quiet !== 1'b1) begin n_err++; $display("[TB] FAIL rstmid discarded: got activity=%b want 0", ~quiet); end
    b = '{8'h81, 8'h00, 8'h00, 8'h00};
    p = '{0, 0, 0, 0};
    model_frames(b, p, 1, n, le, de, be, re);
    run_seq(b, p, 1, n, lg, dg, bg, rg, to);
    n_cmp += 5;
    if (to !== 1'b0) begin n_err++; $display("[TB] FAIL rstmid_resend timeout: got %b want 0", to); end
    if (lg !== le) begin n_err++; $display("[TB] FAIL rstmid_resend tx: got %h want %h", lg, le); end
    if (dg !== de) begin n_err++; $display("[TB] FAIL rstmid_resend tx_done: got %h want %h", dg, de); end
    if (bg !== be) begin n_err++; $display("[TB] FAIL rstmid_resend busy: got %h want %h", bg, be); end
    if (rg !== re) begin n_err++; $display("[TB] FAIL rstmid_resend tx_ready: got %h want %h", rg, re); end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b [4];
    int p [4];
    int n;
    bit to;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    b = '{8'h07, 8'h03, 8'h00, 8'h00};
    p = '{0, 3, 0, 0};
    model_frames(b, p, 2, n, le, de, be, re);
    run_seq(b, p, 2, n, lg, dg, bg, rg, to);
    n_cmp += 6;
    if (to !== 1'b0) begin n_err++; $display("[TB] FAIL parity timeout: got %b want 0", to); end
    if (lg !== le) begin n_err++; $display("[TB] FAIL parity tx: got %h want %h", lg, le); end
    if (dg !== de) begin n_err++; $display("[TB] FAIL parity tx_done: got %h want %h", dg, de); end
    if (bg !== be) begin n_err++; $display("[TB] FAIL parity busy: got %h want %h", bg, be); end
    if (lg[1+9*D+1] !== 1'b1)  begin n_err++; $display("[TB] FAIL parity bit_07: got %b want 1", lg[1+9*D+1]); end
    if (lg[FL+1+9*D+1] !== 1'b0) begin n_err++; $display("[TB] FAIL parity bit_03: got %b want 0", lg[FL+1+9*D+1]); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] b [4];
    int p [4];
    int n, nb;
    bit to;
    logic [W-1:0] le, de, be, re, lg, dg, bg, rg;
    for (int it = 0; it < 10; it++) begin
      b  = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
      p  = '{0, int'($urandom_range(1, FL + 6)), 0, 0};
      nb = ($urandom_range(0, 4) == 0) ? 1 : 2;
      model_frames(b, p, nb, n, le, de, be, re);
      run_seq(b, p, nb, n, lg, dg, bg, rg, to);
      n_cmp += 5;
      if (to !== 1'b0) begin n_err++; $display("[TB] FAIL rand%0d timeout: got %b want 0", it, to); end
      if (lg !== le) begin n_err++; $display("[TB] FAIL rand%0d tx: got %h want %h", it, lg, le); end
      if (dg !== de) begin n_err++; $display("[TB] FAIL rand%0d tx_done: got %h want %h", it, dg, de); end
      if (bg !== be) begin n_err++; $display("[TB] FAIL rand%0d busy: got %h want %h", it, bg, be); end
      if (rg !== re) begin n_err++; $display("[TB] FAIL rand%0d tx_ready: got %h want %h", it, rg, re); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stop_handshake();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("[TB] FAIL watchdog: got still running want finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
